// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Word-addressed data-memory responder with programmable wait states,
//            pipeline stall generation and a saturating access counter.
//            Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        stall_M,
    output logic [15:0] access_cnt,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         c_DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic                r_write;
    logic [31:0]         r_wdata;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_mem [c_DEPTH];
    logic [31:0]         r_rdata;
    logic [15:0]         r_access_cnt;

    logic                w_accept;
    logic                w_enter_resp;
    logic                w_eff_write;
    logic [31:0]         w_eff_wdata;
    logic [ADDR_W-1:0]   w_eff_addr;
    logic                w_eff_mis;
    logic                w_unused_addr;

    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_enter_resp = (w_next == RESP);

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the access attributes must come straight from the request inputs.
    assign w_eff_write  = (r_state == IDLE) ? req_write : r_write;
    assign w_eff_wdata  = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_eff_addr   = (r_state == IDLE) ? req_addr[ADDR_W+1:2] : r_addr;

    assign w_unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_mis;
    logic r_err;

    assign w_eff_mis = (r_state == IDLE) ? (req_addr[1:0] != 2'b00) : r_mis;

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_mis <= (req_addr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_resp && w_eff_mis;
        end
    end

    assign err = r_err;
`else
    assign w_eff_mis = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_next     = WAIT;
                        w_cnt_next = c_WAIT_INIT;
                    end else begin
                        w_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_rdata      <= 32'd0;
            r_access_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_enter_resp && !w_eff_write && !w_eff_mis) begin
                r_rdata <= r_mem[w_eff_addr];
            end else begin
                r_rdata <= 32'd0;
            end
            if ((r_state == RESP) && (r_access_cnt != 16'hFFFF)) begin
                r_access_cnt <= r_access_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_addr  <= req_addr[ADDR_W+1:2];
        end
    end

    // Array is deliberately outside reset; a reset edge only suppresses the commit.
    always_ff @(posedge CLK) begin
        if (reset && w_enter_resp && w_eff_write && !w_eff_mis) begin
            r_mem[w_eff_addr] <= w_eff_wdata;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign stall_M    = (r_state == WAIT) || ((r_state == IDLE) && req_valid);
    assign access_cnt = r_access_cnt;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be: ADDR_W default 8, word-address bits giving a 2^ADDR_W x 32 array; WAIT_CYCLES default 2, wait states inserted before each response, legal range 0-15.
REQ-002 Port list SHALL be:
- CLK  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  memory stage presents an access.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data; zero for stores.
- stall_M  out  1  pipeline freeze request.
- access_cnt  out  16  completed-access counter.
- err  out  1  misaligned access flag (see Configuration).

Function
REQ-003 The FSM SHALL have three states, IDLE, WAIT and RESP, and SHALL leave reset in IDLE.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid=1 and req_ready=1.
REQ-005 On acceptance the block SHALL latch req_write, req_wdata and word address req_addr[ADDR_W+1:2]; later changes on the req_* inputs SHALL NOT affect the access in flight.
REQ-006 Leaving IDLE on acceptance, the next state SHALL be WAIT with a 4-bit counter loaded with WAIT_CYCLES-1 if WAIT_CYCLES>0, else RESP.
REQ-007 In WAIT the counter SHALL decrement by one per cycle; when the counter is 0 the next state SHALL be RESP.
REQ-008 resp_valid SHALL be 1 for exactly the one cycle spent in RESP, which SHALL fall WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-009 RESP SHALL always transition to IDLE.
REQ-010 Stores SHALL write the array on the edge entering RESP.
REQ-011 Loads SHALL present the array word read at the latched address on resp_rdata during RESP.
REQ-012 resp_rdata SHALL be 0 whenever resp_valid=0 and for store responses.
REQ-013 stall_M SHALL be combinational and equal (state==WAIT) OR (state==IDLE AND req_valid).
- Back-to-back requests therefore see exactly one non-stalled cycle, the RESP cycle, per access.
REQ-014 A load to the address of the immediately preceding store SHALL return the stored data.
- No bypass is needed: the write commits before the load is accepted.
REQ-015 access_cnt SHALL increment by 1 on every RESP cycle and SHALL saturate at 16'hFFFF.
REQ-016 Address bits above ADDR_W+1 SHALL be ignored, so addresses alias modulo 2^(ADDR_W+2).

Reset
REQ-017 When reset=0 at an edge:
- state SHALL become IDLE;
- the counter, access_cnt, err, resp_valid and resp_rdata SHALL be 0;
- req_ready SHALL be 1 from the next cycle.
REQ-018 Reset asserted during WAIT SHALL abort the access in flight: no array write occurs and no resp_valid pulse is produced.
REQ-019 Array contents SHALL NOT be altered by reset.

Configuration
REQ-020 The feature SHALL be controlled by macro DMEM_MISALIGN_TRAP_EN.
- Defined: an accepted request with req_addr[1:0]!=0 SHALL skip the array write, return resp_rdata=0 and set err=1 in its RESP cycle. It SHALL still count in access_cnt and still follow the normal timing.
- Undefined: req_addr[1:0] SHALL be ignored, err SHALL be tied to 0, and the misaligned-access logic SHALL NOT be present in the netlist.

Verification
REQ-021 Reset, then hold req_valid=0 for 5 cycles. Required: req_ready=1, resp_valid=0, stall_M=0, access_cnt=0 throughout.
REQ-022 With WAIT_CYCLES=2, store 0xDEADBEEF to 0x10, then load 0x10. Required:
- each resp_valid rises 3 cycles after its acceptance;
- stall_M is high for the 3 cycles from request to response;
- the load returns 0xDEADBEEF;
- access_cnt=2.
REQ-023 With WAIT_CYCLES=0, issue back-to-back loads from 0x0 and 0x4 (preloaded 0x11, 0x22). Required: resp_valid on consecutive alternate cycles, with data 0x11 then 0x22.
REQ-024 Change req_addr and req_wdata during WAIT of a store to 0x20. Required: only word 0x20 is written, with the originally latched data.
REQ-025 Pull reset low in the second WAIT cycle of a store to 0x40 (old value 0x5). Required: no resp_valid pulse, and a later load of 0x40 returns 0x5.
REQ-026 With DMEM_MISALIGN_TRAP_EN defined, store to 0x42. Required: err=1 and resp_rdata=0 in RESP, and word 0x40 is unchanged. Without the macro, the same store writes word 0x40 and err stays 0.
